// File: rtl/pop_pkg.sv
// Shared types and default constants for the POP Ramsey-cycle sequencer.
package pop_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUMP  = 3'd1,
    S_GAP1  = 3'd2,
    S_MW    = 3'd3,
    S_PREC  = 3'd4,
    S_GAP2  = 3'd5,
    S_PROBE = 3'd6,
    S_POST  = 3'd7
  } state_t;

  localparam int N_MW_MAX = 15;

  localparam int DEF_WIDTH        = 16;
  localparam int DEF_N_MW         = 2;
  localparam int DEF_PUMP_LEN     = 1000;
  localparam int DEF_GAP_LEN      = 125;
  localparam int DEF_PIO2         = 1000;
  localparam int DEF_PIO2_STEP    = 25;
  localparam int DEF_PIO2_MIN     = 25;
  localparam int DEF_PIO2_MAX     = 5000;
  localparam int DEF_FP           = 7500;
  localparam int DEF_FP_STEP      = 200;
  localparam int DEF_FP_MIN       = 200;
  localparam int DEF_FP_MAX       = 30000;
  localparam int DEF_PROBE_LEN    = 375;
  localparam int DEF_SAMPLE_DELAY = 0;
  localparam int DEF_SAMPLE_LEN   = 125;
  localparam int DEF_POST_LEN     = 500;
  localparam int DEF_CNT_WIDTH    = 16;

endpackage

// File: rtl/pop_adjust_reg.sv
// Button-driven length register: rising-edge detect on plus/minus and a
// saturating step up/down clamped to [MIN, MAX].
module pop_adjust_reg #(
  parameter int WIDTH = 16,
  parameter int DEF   = 1000,
  parameter int STEP  = 25,
  parameter int MIN   = 25,
  parameter int MAX   = 5000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_plus,
  input  logic             i_minus,
  output logic [WIDTH-1:0] o_val
);

  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MIN_W  = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] DEF_V  = WIDTH'(DEF);

  logic             r_plus_q;
  logic             r_minus_q;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] w_val_nxt;
  logic [WIDTH:0]   w_up;
  logic             w_rise_p;
  logic             w_rise_m;

  assign w_rise_p = i_plus & ~r_plus_q;
  assign w_rise_m = i_minus & ~r_minus_q;

  // One extra bit of headroom so neither direction can wrap before the clamp.
  always_comb begin
    w_up      = {1'b0, r_val} + STEP_W;
    w_val_nxt = r_val;
    if (w_rise_p && !w_rise_m) begin
      if (w_up > MAX_W) w_val_nxt = MAX_W[WIDTH-1:0];
      else              w_val_nxt = w_up[WIDTH-1:0];
    end else if (w_rise_m && !w_rise_p) begin
      if ({1'b0, r_val} < (MIN_W + STEP_W)) w_val_nxt = MIN_W[WIDTH-1:0];
      else                                  w_val_nxt = r_val - STEP_W[WIDTH-1:0];
    end else begin
      w_val_nxt = r_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_plus_q  <= 1'b0;
      r_minus_q <= 1'b0;
      r_val     <= DEF_V;
    end else begin
      r_plus_q  <= i_plus;
      r_minus_q <= i_minus;
      r_val     <= w_val_nxt;
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/pop_sequencer.sv
// Ramsey-cycle gate generator: Moore FSM plus segment counter producing pump,
// MW, probe and sample gates, with per-cycle latched pi/2 and precession lengths.
module pop_sequencer
  import pop_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int N_MW         = DEF_N_MW,
  parameter int PUMP_LEN     = DEF_PUMP_LEN,
  parameter int GAP_LEN      = DEF_GAP_LEN,
  parameter int PIO2_DEF     = DEF_PIO2,
  parameter int PIO2_STEP    = DEF_PIO2_STEP,
  parameter int PIO2_MIN     = DEF_PIO2_MIN,
  parameter int PIO2_MAX     = DEF_PIO2_MAX,
  parameter int FP_DEF       = DEF_FP,
  parameter int FP_STEP      = DEF_FP_STEP,
  parameter int FP_MIN       = DEF_FP_MIN,
  parameter int FP_MAX       = DEF_FP_MAX,
  parameter int PROBE_LEN    = DEF_PROBE_LEN,
  parameter int SAMPLE_DELAY = DEF_SAMPLE_DELAY,
  parameter int SAMPLE_LEN   = DEF_SAMPLE_LEN,
  parameter int POST_LEN     = DEF_POST_LEN,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                 clk_2M5,
  input  logic                 load_defaults_n,
  input  logic                 run,
  input  logic                 single_shot,
  input  logic                 pio2_plus,
  input  logic                 pio2_minus,
  input  logic                 fp_plus,
  input  logic                 fp_minus,
  output logic                 pump,
  output logic                 MW,
  output logic                 probe,
  output logic                 sample,
  output logic                 busy,
  output logic                 cycle_done,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [WIDTH-1:0]     pio2_len,
  output logic [WIDTH-1:0]     fp_len
);

  localparam int               K_W      = $clog2(N_MW_MAX + 1);
  localparam logic [K_W-1:0]   K_ZERO   = {K_W{1'b0}};
  localparam logic [K_W-1:0]   K_LAST   = K_W'(N_MW - 1);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] PUMP_L1  = WIDTH'(PUMP_LEN - 1);
  localparam logic [WIDTH-1:0] GAP_L1   = WIDTH'(GAP_LEN - 1);
  localparam logic [WIDTH-1:0] PROBE_L1 = WIDTH'(PROBE_LEN - 1);
  localparam logic [WIDTH-1:0] POST_L1  = WIDTH'(POST_LEN - 1);

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_seg, w_seg_nxt;
  logic [K_W-1:0]       r_k, w_k_nxt;
  logic [WIDTH-1:0]     r_pio2_sh, r_fp_sh;
  logic                 r_ss, r_hold;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_pump, r_mw, r_probe, r_sample, r_busy, r_done;
  logic                 w_pump, w_mw, w_probe, w_sample, w_busy, w_done;
  logic                 w_last, w_enter_pump, w_post_exit;
  logic [WIDTH-1:0]     w_probe_off;

  pop_adjust_reg #(.WIDTH(WIDTH), .DEF(PIO2_DEF), .STEP(PIO2_STEP), .MIN(PIO2_MIN), .MAX(PIO2_MAX))
    u_pio2 (.i_clk(clk_2M5), .i_rst_n(load_defaults_n), .i_plus(pio2_plus), .i_minus(pio2_minus), .o_val(pio2_len));

  pop_adjust_reg #(.WIDTH(WIDTH), .DEF(FP_DEF), .STEP(FP_STEP), .MIN(FP_MIN), .MAX(FP_MAX))
    u_fp (.i_clk(clk_2M5), .i_rst_n(load_defaults_n), .i_plus(fp_plus), .i_minus(fp_minus), .o_val(fp_len));

  assign w_last       = (r_seg == W_ZERO);
  assign w_enter_pump = (w_state_nxt == S_PUMP) && (r_state != S_PUMP);
  assign w_post_exit  = (r_state == S_POST) && w_last;

  always_ff @(posedge clk_2M5 or negedge load_defaults_n) begin
    if (!load_defaults_n) begin
      r_state <= S_IDLE;
      r_seg   <= W_ZERO;
      r_k     <= K_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_seg   <= w_seg_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Each segment loads its length minus one on entry and leaves when it hits zero.
  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = r_seg - W_ONE;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        w_seg_nxt = W_ZERO;
        if (run && !r_hold) begin
          w_state_nxt = S_PUMP;
          w_seg_nxt   = PUMP_L1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PUMP: begin
        if (w_last) begin w_state_nxt = S_GAP1; w_seg_nxt = GAP_L1; end
        else        begin w_state_nxt = S_PUMP; end
      end
      S_GAP1: begin
        if (w_last) begin w_state_nxt = S_MW; w_seg_nxt = r_pio2_sh - W_ONE; w_k_nxt = K_ZERO; end
        else        begin w_state_nxt = S_GAP1; end
      end
      S_MW: begin
        if (w_last && (r_k != K_LAST)) begin
          w_state_nxt = S_PREC;
          w_seg_nxt   = r_fp_sh - W_ONE;
          w_k_nxt     = r_k + K_W'(1);
        end else if (w_last) begin
          w_state_nxt = S_GAP2;
          w_seg_nxt   = GAP_L1;
        end else begin
          w_state_nxt = S_MW;
        end
      end
      S_PREC: begin
        if (w_last) begin w_state_nxt = S_MW; w_seg_nxt = r_pio2_sh - W_ONE; end
        else        begin w_state_nxt = S_PREC; end
      end
      S_GAP2: begin
        if (w_last) begin w_state_nxt = S_PROBE; w_seg_nxt = PROBE_L1; end
        else        begin w_state_nxt = S_GAP2; end
      end
      S_PROBE: begin
        if (w_last) begin w_state_nxt = S_POST; w_seg_nxt = POST_L1; end
        else        begin w_state_nxt = S_PROBE; end
      end
      S_POST: begin
        if (w_last && run && !r_ss) begin
          w_state_nxt = S_PUMP;
          w_seg_nxt   = PUMP_L1;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
          w_seg_nxt   = W_ZERO;
        end else begin
          w_state_nxt = S_POST;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_seg_nxt   = W_ZERO;
        w_k_nxt     = K_ZERO;
      end
    endcase
  end

  // Gates are decoded from the next state so the registered copies line up with r_state.
  always_comb begin
    w_probe_off = PROBE_L1 - w_seg_nxt;
    w_pump      = (w_state_nxt == S_PUMP);
    w_mw        = (w_state_nxt == S_MW);
    w_probe     = (w_state_nxt == S_PROBE);
    w_sample    = w_probe && (int'(w_probe_off) >= SAMPLE_DELAY)
                          && (int'(w_probe_off) < (SAMPLE_DELAY + SAMPLE_LEN));
    w_busy      = (w_state_nxt != S_IDLE);
    w_done      = (w_state_nxt == S_POST) && (w_seg_nxt == W_ZERO);
  end

  always_ff @(posedge clk_2M5 or negedge load_defaults_n) begin
    if (!load_defaults_n) begin
      r_pump   <= 1'b0;
      r_mw     <= 1'b0;
      r_probe  <= 1'b0;
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_pump   <= w_pump;
      r_mw     <= w_mw;
      r_probe  <= w_probe;
      r_sample <= w_sample;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  // A finished single shot blocks restart until run is released.
  always_ff @(posedge clk_2M5 or negedge load_defaults_n) begin
    if (!load_defaults_n) begin
      r_pio2_sh <= WIDTH'(PIO2_DEF);
      r_fp_sh   <= WIDTH'(FP_DEF);
      r_ss      <= 1'b0;
      r_hold    <= 1'b0;
      r_count   <= {CNT_WIDTH{1'b0}};
    end else begin
      if (w_enter_pump) begin
        r_pio2_sh <= pio2_len;
        r_fp_sh   <= fp_len;
        r_ss      <= single_shot;
      end else begin
        r_pio2_sh <= r_pio2_sh;
        r_fp_sh   <= r_fp_sh;
        r_ss      <= r_ss;
      end
      if (w_post_exit) r_count <= r_count + CNT_WIDTH'(1);
      else             r_count <= r_count;
      if (w_post_exit && r_ss) r_hold <= 1'b1;
      else if (!run)           r_hold <= 1'b0;
      else                     r_hold <= r_hold;
    end
  end

  assign pump        = r_pump;
  assign MW          = r_mw;
  assign probe       = r_probe;
  assign sample      = r_sample;
  assign busy        = r_busy;
  assign cycle_done  = r_done;
  assign cycle_count = r_count;

endmodule

// File: tb/tb_pop_sequencer.sv
// Self-checking bench for pop_sequencer: directed plus random stimulus against
// a cycle-position model that derives every gate from the segment arithmetic.
module tb_pop_sequencer;

  localparam int PUMP = 4, GAP = 2, PIO2_DEF = 3, FP_DEF = 5, PROBE = 6;
  localparam int SDEL = 1, SLEN = 2, POST = 3, NMW = 2;
  localparam int PMIN = 1, PMAX = 8, FMIN = 1, FMAX = 9, CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, run, ss, pp, pm, fpp, fpm;
  logic pump, mw, probe, sample, busy, done;
  logic [CW-1:0] cnt;
  logic [15:0]   pio2, fp;

  int tests = 0;
  int fails = 0;

  bit m_act, m_hold, m_ss, m_pp_q, m_pm_q, m_fpp_q, m_fpm_q;
  int m_t, m_p, m_f, m_pio2, m_fp, m_cnt;

  pop_sequencer #(
    .WIDTH(16), .N_MW(NMW), .PUMP_LEN(PUMP), .GAP_LEN(GAP),
    .PIO2_DEF(PIO2_DEF), .PIO2_STEP(1), .PIO2_MIN(PMIN), .PIO2_MAX(PMAX),
    .FP_DEF(FP_DEF), .FP_STEP(1), .FP_MIN(FMIN), .FP_MAX(FMAX),
    .PROBE_LEN(PROBE), .SAMPLE_DELAY(SDEL), .SAMPLE_LEN(SLEN), .POST_LEN(POST),
    .CNT_WIDTH(CW)
  ) dut (
    .clk_2M5(clk), .load_defaults_n(rst_n), .run(run), .single_shot(ss),
    .pio2_plus(pp), .pio2_minus(pm), .fp_plus(fpp), .fp_minus(fpm),
    .pump(pump), .MW(mw), .probe(probe), .sample(sample), .busy(busy),
    .cycle_done(done), .cycle_count(cnt), .pio2_len(pio2), .fp_len(fp)
  );

  function automatic int period(input int p, input int f);
    return PUMP + 2*GAP + NMW*p + (NMW-1)*f + PROBE + POST;
  endfunction

  function automatic int adj(input int v, input bit up, input bit dn, input int mn, input int mx);
    if (up && !dn) return (v + 1 > mx) ? mx : v + 1;
    if (dn && !up) return (v - 1 < mn) ? mn : v - 1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_hold = 0; m_ss = 0; m_t = 0; m_cnt = 0;
    m_pio2 = PIO2_DEF; m_fp = FP_DEF; m_p = PIO2_DEF; m_f = FP_DEF;
    m_pp_q = 0; m_pm_q = 0; m_fpp_q = 0; m_fpm_q = 0;
  endtask

  task automatic model_step();
    bit ended_ss;
    ended_ss = 0;
    if (!m_act) begin
      if (run && !m_hold) begin
        m_act = 1; m_t = 0; m_p = m_pio2; m_f = m_fp; m_ss = ss;
      end
    end else begin
      m_t++;
      if (m_t == period(m_p, m_f)) begin
        m_cnt++;
        if (run && !m_ss) begin
          m_t = 0; m_p = m_pio2; m_f = m_fp; m_ss = ss;
        end else begin
          m_act = 0; ended_ss = m_ss;
        end
      end
    end
    if (ended_ss) m_hold = 1;
    else if (!run) m_hold = 0;
    m_pio2 = adj(m_pio2, pp & ~m_pp_q, pm & ~m_pm_q, PMIN, PMAX);
    m_fp   = adj(m_fp, fpp & ~m_fpp_q, fpm & ~m_fpm_q, FMIN, FMAX);
    m_pp_q = pp; m_pm_q = pm; m_fpp_q = fpp; m_fpm_q = fpm;
  endtask

  task automatic check_all();
    bit e_pump, e_mw, e_probe, e_sample, e_done;
    int base, ps, s;
    e_pump = 0; e_mw = 0; e_probe = 0; e_sample = 0; e_done = 0;
    if (m_act) begin
      base = PUMP + GAP;
      e_pump = (m_t < PUMP);
      for (int k = 0; k < NMW; k++) begin
        s = base + k*(m_p + m_f);
        if (m_t >= s && m_t < s + m_p) e_mw = 1;
      end
      ps = base + NMW*m_p + (NMW-1)*m_f + GAP;
      e_probe  = (m_t >= ps) && (m_t < ps + PROBE);
      e_sample = (m_t >= ps + SDEL) && (m_t < ps + SDEL + SLEN);
      e_done   = (m_t == period(m_p, m_f) - 1);
    end
    chk("busy", busy, m_act);
    chk("pump", pump, e_pump);
    chk("mw", mw, e_mw);
    chk("probe", probe, e_probe);
    chk("sample", sample, e_sample);
    chk("cycle_done", done, e_done);
    chk("cycle_count", cnt, m_cnt % (1 << CW));
    chk("pio2_len", pio2, m_pio2);
    chk("fp_len", fp, m_fp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // which: 0 = MW high, 1 = probe high, 2 = idle, 3 = MW low
  task automatic wait_until(input int which, input string tag);
    int n;
    logic hit;
    n = 0;
    hit = 0;
    while (n < 200) begin
      case (which)
        0:       hit = mw;
        1:       hit = probe;
        2:       hit = ~busy;
        default: hit = ~mw;
      endcase
      if (hit === 1'b1) break;
      tick();
      n++;
    end
    chk(tag, hit, 1'b1);
  endtask

  initial begin
    rst_n = 0; run = 0; ss = 0; pp = 0; pm = 0; fpp = 0; fpm = 0;
    model_reset();
    #12;
    check_all();
    chk("rst_pio2", pio2, 16'd3);
    chk("rst_fp", fp, 16'd5);
    rst_n = 1;
    tick();

    // continuous run: first cycle ends after 28 clocks
    run = 1;
    ticks(28);
    chk("first_done", done, 1'b1);
    tick();
    chk("count_after_period", cnt, 4'd1);
    chk("restart_pump", pump, 1'b1);
    ticks(56);
    run = 0;
    wait_until(2, "drain_idle");

    // single shot with run held
    ss = 1; run = 1;
    ticks(40);
    chk("ss_one_cycle_idle", busy, 1'b0);
    run = 0; ss = 0;
    tick();

    // pi/2 bump during MW is visible at once, used next cycle
    run = 1;
    wait_until(0, "wait_mw");
    pp = 1;
    tick();
    chk("pio2_inc", pio2, 16'd4);
    pp = 0;
    ticks(70);

    // fp saturation at MIN and simultaneous plus/minus
    for (int i = 0; i < 10; i++) begin
      fpm = 1; tick();
      fpm = 0; tick();
    end
    chk("fp_sat_min", fp, 16'd1);
    fpp = 1; fpm = 1; pp = 1; pm = 1;
    tick();
    chk("fp_both_edges", fp, 16'd1);
    chk("pio2_both_edges", pio2, 16'd4);
    fpp = 0; fpm = 0; pp = 0; pm = 0;
    tick();

    // random control and buttons
    for (int i = 0; i < 600; i++) begin
      run = ($urandom_range(0, 9) != 0);
      ss  = ($urandom_range(0, 7) == 0);
      pp  = ($urandom_range(0, 5) == 0);
      pm  = ($urandom_range(0, 5) == 0);
      fpp = ($urandom_range(0, 5) == 0);
      fpm = ($urandom_range(0, 5) == 0);
      tick();
    end
    pp = 0; pm = 0; fpp = 0; fpm = 0; ss = 0; run = 1;

    // async reset in the middle of PROBE
    wait_until(1, "wait_probe");
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    chk("rst_mid_probe", probe, 1'b0);
    #3;
    rst_n = 1;

    // count wraps at 16, then run drops in the precession gap
    begin
      int n;
      n = 0;
      while (m_cnt < 17 && n < 2000) begin
        tick();
        n++;
      end
      chk("wrap_reached", m_cnt, 17);
      chk("count_wrapped", cnt, 4'd1);
    end
    wait_until(0, "wait_mw2");
    wait_until(3, "wait_prec");
    run = 0;
    tick();
    chk("prec_continues", busy, 1'b1);
    wait_until(2, "stop_idle");
    chk("final_count", cnt, 4'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
